// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: groups the core-side request/response handshake and the
// data-memory port of the load/store unit into one bundle.
//   slave  modport : the load/store unit (takes requests, drives memory).
//   master modport : the environment (core execute stage + memory model).
// Signals:
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata/req_rd  request
//   resp_valid/resp_rdata/resp_rd/resp_err                           response
//   mem_req/mem_we/mem_addr/mem_strb/mem_wdata/mem_ack/mem_rdata     memory
interface lsu_ctrl_if #(
    parameter int XLEN = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [2:0]           req_funct3;
    logic [XLEN-1:0]      req_addr;
    logic [XLEN-1:0]      req_wdata;
    logic [4:0]           req_rd;

    logic                 resp_valid;
    logic [XLEN-1:0]      resp_rdata;
    logic [4:0]           resp_rd;
    logic [1:0]           resp_err;

    logic                 mem_req;
    logic                 mem_we;
    logic [XLEN-1:0]      mem_addr;
    logic [XLEN/8-1:0]    mem_strb;
    logic [XLEN-1:0]      mem_wdata;
    logic                 mem_ack;
    logic [XLEN-1:0]      mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output req_ready,
        output resp_valid, resp_rdata, resp_rd, resp_err,
        output mem_req, mem_we, mem_addr, mem_strb, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_rd, resp_err,
        input  mem_req, mem_we, mem_addr, mem_strb, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding RISC-V load/store unit between the execute
// stage and a variable-latency data-memory port.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - lsu_ctrl_if.slave: request/response handshake and memory port
// Flow: IDLE accepts a request; illegal funct3 or misaligned addresses go
// straight to RESP with an error; legal accesses go to ISSUE and hold mem_req
// until mem_ack or until TIMEOUT cycles pass; RESP pulses resp_valid once.
module lsu_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    lsu_ctrl_if.slave       bus
);
    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state_q;
    logic [7:0]        cnt_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [LW-1:0]     lane_q;
    logic [4:0]        rd_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [XLEN-1:0]   mem_addr_q;
    logic [NB-1:0]     mem_strb_q;
    logic [XLEN-1:0]   mem_wdata_q;
    logic              resp_valid_q;
    logic [XLEN-1:0]   resp_rdata_q;
    logic [1:0]        resp_err_q;

    logic [LW-1:0]     lane_d;
    logic [XLEN-1:0]   addr_al_d;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 inside {3'b000, 3'b001, 3'b010}) ||
                   (XLEN == 64 && f3 == 3'b011);
        else
            return (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                   (XLEN == 64 && (f3 == 3'b011 || f3 == 3'b110));
    endfunction

    // Access size in bytes is encoded by funct3[1:0] for every legal code.
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return |a[1:0];
            2'b11:   return |a[2:0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [NB-1:0] strobe(input logic [2:0] f3, input logic [LW-1:0] lane);
        logic [NB-1:0] s;
        for (int i = 0; i < NB; i++)
            s[i] = (i >= int'(lane)) && (i < int'(lane) + nbytes(f3));
        return s;
    endfunction

    // Bytes above the access size are zeroed before the lane shift so the
    // unused lanes never carry stale register contents onto the bus.
    function automatic logic [XLEN-1:0] place(input logic [2:0] f3,
                                               input logic [XLEN-1:0] wd,
                                               input logic [LW-1:0] lane);
        logic [XLEN-1:0] m;
        for (int i = 0; i < XLEN; i++)
            m[i] = (i < 8 * nbytes(f3));
        return (wd & m) << {lane, 3'b000};
    endfunction

    function automatic logic [XLEN-1:0] extend(input logic [2:0] f3,
                                                input logic [XLEN-1:0] word,
                                                input logic [LW-1:0] lane);
        logic [XLEN-1:0] sh;
        sh = word >> {lane, 3'b000};
        case (f3)
            3'b000:  return XLEN'($signed(sh[7:0]));
            3'b001:  return XLEN'($signed(sh[15:0]));
            3'b010:  return XLEN'($signed(sh[31:0]));
            3'b100:  return XLEN'(sh[7:0]);
            3'b101:  return XLEN'(sh[15:0]);
            3'b110:  return XLEN'(sh[31:0]);
            default: return sh;
        endcase
    endfunction

    assign lane_d    = bus.req_addr[LW-1:0];
    assign addr_al_d = {bus.req_addr[XLEN-1:LW], {LW{1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            f3_q         <= '0;
            lane_q       <= '0;
            rd_q         <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_strb_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 2'b00;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q   <= bus.req_we;
                        f3_q   <= bus.req_funct3;
                        lane_q <= lane_d;
                        rd_q   <= bus.req_rd;
                        if (!f3_legal(bus.req_we, bus.req_funct3)) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 2'b11;
                            resp_rdata_q <= '0;
                        end else if (misaligned(bus.req_funct3, bus.req_addr[2:0])) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 2'b01;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q     <= ISSUE;
                            cnt_q       <= '0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= bus.req_we;
                            mem_addr_q  <= addr_al_d;
                            mem_strb_q  <= bus.req_we ? strobe(bus.req_funct3, lane_d) : '0;
                            mem_wdata_q <= bus.req_we ?
                                           place(bus.req_funct3, bus.req_wdata, lane_d) : '0;
                        end
                    end
                end
                ISSUE: begin
                    // An ack in the same cycle the counter expires still wins.
                    if (bus.mem_ack) begin
                        state_q      <= RESP;
                        mem_req_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 2'b00;
                        resp_rdata_q <= we_q ? '0 : extend(f3_q, bus.mem_rdata, lane_q);
                    end else if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
                        state_q      <= RESP;
                        mem_req_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 2'b10;
                        resp_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_rd    = rd_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_strb   = mem_strb_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl with one XLEN=32/TIMEOUT=4 and
// one XLEN=64/TIMEOUT=16 instance. A byte-level reference model derives the
// expected bus and response values; a negedge process compares every cycle.
module tb_lsu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bit          sel = 1'b0;          // 0 = 32-bit unit, 1 = 64-bit unit
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_f3 = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = '0;

    lsu_ctrl_if #(.XLEN(32)) if32();
    lsu_ctrl_if #(.XLEN(64)) if64();

    lsu_ctrl #(.XLEN(32), .TIMEOUT(4))  dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
    lsu_ctrl #(.XLEN(64), .TIMEOUT(16)) dut64 (.clk(clk), .rst(rst), .bus(if64.slave));

    assign if32.req_valid  = req_valid & ~sel;
    assign if32.req_we     = req_we;
    assign if32.req_funct3 = req_f3;
    assign if32.req_addr   = req_addr[31:0];
    assign if32.req_wdata  = req_wdata[31:0];
    assign if32.req_rd     = req_rd;
    assign if32.mem_ack    = mem_ack & ~sel;
    assign if32.mem_rdata  = mem_rdata[31:0];

    assign if64.req_valid  = req_valid & sel;
    assign if64.req_we     = req_we;
    assign if64.req_funct3 = req_f3;
    assign if64.req_addr   = req_addr;
    assign if64.req_wdata  = req_wdata;
    assign if64.req_rd     = req_rd;
    assign if64.mem_ack    = mem_ack & sel;
    assign if64.mem_rdata  = mem_rdata;

    logic        o_ready, o_mem_req, o_mem_we, o_rv;
    logic [63:0] o_addr, o_wd, o_rdata;
    logic [7:0]  o_strb;
    logic [4:0]  o_rd;
    logic [1:0]  o_err;

    always_comb begin
        o_ready   = sel ? if64.req_ready  : if32.req_ready;
        o_mem_req = sel ? if64.mem_req    : if32.mem_req;
        o_mem_we  = sel ? if64.mem_we     : if32.mem_we;
        o_rv      = sel ? if64.resp_valid : if32.resp_valid;
        o_addr    = sel ? if64.mem_addr   : {32'b0, if32.mem_addr};
        o_wd      = sel ? if64.mem_wdata  : {32'b0, if32.mem_wdata};
        o_rdata   = sel ? if64.resp_rdata : {32'b0, if32.resp_rdata};
        o_strb    = sel ? if64.mem_strb   : {4'b0, if32.mem_strb};
        o_rd      = sel ? if64.resp_rd    : if32.resp_rd;
        o_err     = sel ? if64.resp_err   : if32.resp_err;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: works byte by byte from the access rules.
    task automatic model(input int xl, input bit we, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata,
                         output logic [1:0] err, output logic [63:0] maddr,
                         output logic [7:0] strb, output logic [63:0] mwd,
                         output logic [63:0] rres);
        int  nb, lane, size;
        bit  legal;
        longint unsigned v, xmask;
        nb    = xl / 8;
        lane  = int'(addr % 64'(nb));
        size  = 1 << f3[1:0];
        xmask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        if (we) legal = (f3 <= 3'd2) || (xl == 64 && f3 == 3'd3);
        else    legal = (f3 <= 3'd2) || f3 == 3'd4 || f3 == 3'd5 ||
                        (xl == 64 && (f3 == 3'd3 || f3 == 3'd6));
        if (!legal)                      err = 2'b11;
        else if (addr % 64'(size) != 0)  err = 2'b01;
        else                             err = 2'b00;
        maddr = (addr - 64'(lane)) & xmask;
        strb  = we ? 8'(((1 << size) - 1) << lane) : 8'h00;
        mwd   = '0;
        for (int i = 0; i < size; i++)
            mwd = mwd | (((wdata >> (8 * i)) & 64'hFF) << (8 * (lane + i)));
        mwd = mwd & xmask;
        v = 0;
        for (int i = 0; i < size; i++)
            v = v | (((rdata >> (8 * (lane + i))) & 64'hFF) << (8 * i));
        if (!f3[2] && size * 8 < xl && v[size * 8 - 1])
            v = v | ~((64'd1 << (size * 8)) - 1);
        rres = we ? 64'd0 : (v & xmask);
    endtask

    bit          chk_en = 1'b0;
    logic        exp_ready, exp_mem_req, exp_rv, exp_we;
    logic [1:0]  exp_err;
    logic [63:0] exp_rdata, exp_addr, exp_wd;
    logic [7:0]  exp_strb;
    logic [4:0]  exp_rd;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 64'(o_ready), 64'(exp_ready));
            chk("mem_req", 64'(o_mem_req), 64'(exp_mem_req));
            chk("resp_valid", 64'(o_rv), 64'(exp_rv));
            if (exp_rv) begin
                chk("resp_err", 64'(o_err), 64'(exp_err));
                chk("resp_rdata", o_rdata, exp_rdata);
                chk("resp_rd", 64'(o_rd), 64'(exp_rd));
            end
            if (exp_mem_req) begin
                chk("mem_we", 64'(o_mem_we), 64'(exp_we));
                chk("mem_addr", o_addr, exp_addr);
                chk("mem_strb", 64'(o_strb), 64'(exp_strb));
                if (exp_we) chk("mem_wdata", o_wd, exp_wd);
            end
        end
    end

    task automatic set_idle();
        exp_ready   = 1'b1;
        exp_mem_req = 1'b0;
        exp_rv      = 1'b0;
    endtask

    // d = cycle of ISSUE in which mem_ack is high (1 = first); 0 = never.
    task automatic txn(input bit s64, input bit we, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] rdata, input int d, input logic [4:0] rd);
        logic [1:0]  e;
        logic [63:0] ma, mw, mr;
        logic [7:0]  ms;
        int          tmo;
        bit          acked;
        model(s64 ? 64 : 32, we, f3, addr, wdata, rdata, e, ma, ms, mw, mr);
        sel = s64; req_we = we; req_f3 = f3; req_addr = addr;
        req_wdata = wdata; req_rd = rd; req_valid = 1'b1;
        set_idle();
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_ready = 1'b0;
        exp_rd    = rd;
        if (e != 2'b00) begin
            exp_mem_req = 1'b0; exp_rv = 1'b1; exp_err = e; exp_rdata = '0;
        end else begin
            tmo = s64 ? 16 : 4;
            acked = 1'b0;
            exp_we = we; exp_addr = ma; exp_strb = ms; exp_wd = mw;
            for (int i = 1; i <= tmo && !acked; i++) begin
                exp_mem_req = 1'b1; exp_rv = 1'b0;
                mem_ack = (i == d); mem_rdata = rdata; acked = (i == d);
                @(posedge clk); #1;
                mem_ack = 1'b0;
            end
            exp_mem_req = 1'b0; exp_rv = 1'b1;
            exp_err   = acked ? 2'b00 : 2'b10;
            exp_rdata = acked ? mr : 64'd0;
        end
        @(posedge clk); #1;
        set_idle();
    endtask

    task automatic reset_vals(input string nm);
        chk({nm, " req_ready"}, 64'(o_ready), 64'd1);
        chk({nm, " mem_req"},   64'(o_mem_req), 64'd0);
        chk({nm, " mem_we"},    64'(o_mem_we), 64'd0);
        chk({nm, " mem_addr"},  o_addr, 64'd0);
        chk({nm, " mem_strb"},  64'(o_strb), 64'd0);
        chk({nm, " mem_wdata"}, o_wd, 64'd0);
        chk({nm, " resp_valid"}, 64'(o_rv), 64'd0);
        chk({nm, " resp_rdata"}, o_rdata, 64'd0);
        chk({nm, " resp_rd"},   64'(o_rd), 64'd0);
        chk({nm, " resp_err"},  64'(o_err), 64'd0);
    endtask

    initial begin
        logic [1:0]  pe;
        logic [63:0] pa, pw, pr;
        logic [7:0]  ps;

        // Hand-computed pins of the reference model itself.
        model(32, 0, 3'b000, 64'h103, 64'h0, 64'h80FF_1234, pe, pa, ps, pw, pr);
        chk("pin LB rdata", pr, 64'hFFFF_FF80);
        chk("pin LB addr", pa, 64'h100);
        model(32, 1, 3'b001, 64'h22, 64'h1234_ABCD, 64'h0, pe, pa, ps, pw, pr);
        chk("pin SH strb", 64'(ps), 64'hC);
        chk("pin SH wdata", pw, 64'hABCD_0000);
        model(32, 0, 3'b010, 64'h6, 64'h0, 64'h0, pe, pa, ps, pw, pr);
        chk("pin LW misaligned", 64'(pe), 64'd1);
        model(32, 0, 3'b011, 64'h0, 64'h0, 64'h0, pe, pa, ps, pw, pr);
        chk("pin LD on 32", 64'(pe), 64'd3);
        model(64, 0, 3'b110, 64'h14, 64'h0, 64'h8765_4321_0000_0000, pe, pa, ps, pw, pr);
        chk("pin LWU rdata", pr, 64'h0000_0000_8765_4321);
        model(64, 1, 3'b011, 64'h8, 64'h0, 64'h0, pe, pa, ps, pw, pr);
        chk("pin SD strb", 64'(ps), 64'hFF);

        // Reset values on both instances.
        #12;
        sel = 1'b0; #1; reset_vals("rst32");
        sel = 1'b1; #1; reset_vals("rst64");
        sel = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        set_idle();
        chk_en = 1'b1;
        @(posedge clk); #1;

        // 32-bit unit, TIMEOUT = 4
        txn(0, 0, 3'b000, 64'h103, 64'h0, 64'h80FF_1234, 1, 5'd5);        // LB
        txn(0, 1, 3'b001, 64'h22, 64'h1234_ABCD, 64'hDEAD_BEEF, 3, 5'd6); // SH
        txn(0, 0, 3'b010, 64'h6, 64'h0, 64'h0, 1, 5'd7);                  // LW misaligned
        txn(0, 0, 3'b011, 64'h0, 64'h0, 64'h0, 1, 5'd8);                  // LD illegal
        txn(0, 1, 3'b100, 64'h0, 64'h0, 64'h0, 1, 5'd9);                  // store f3=100 illegal
        txn(0, 0, 3'b010, 64'h40, 64'h0, 64'h1111_2222, 0, 5'd10);        // timeout
        txn(0, 0, 3'b001, 64'h42, 64'h0, 64'h7FFF_8001, 4, 5'd11);        // LH, ack on 4th
        txn(0, 0, 3'b101, 64'h2, 64'h0, 64'h8001_0000, 2, 5'd12);         // LHU
        txn(0, 1, 3'b010, 64'h10, 64'hCAFE_F00D, 64'h0, 1, 5'd13);        // SW
        txn(0, 1, 3'b000, 64'h7, 64'hFFFF_FFAB, 64'h0, 2, 5'd14);         // SB lane 3

        // 64-bit unit, TIMEOUT = 16
        txn(1, 0, 3'b110, 64'h14, 64'h0, 64'h8765_4321_0000_0000, 1, 5'd15); // LWU
        txn(1, 1, 3'b011, 64'h8, 64'h0123_4567_89AB_CDEF, 64'h0, 2, 5'd16);  // SD
        txn(1, 0, 3'b010, 64'h4, 64'h0, 64'h8000_0000_0000_0000, 1, 5'd17);  // LW sign
        txn(1, 0, 3'b011, 64'h4, 64'h0, 64'h0, 1, 5'd18);                    // LD misaligned
        txn(1, 0, 3'b000, 64'h7, 64'h0, 64'hFF00_0000_0000_0000, 5, 5'd19);  // LB lane 7
        txn(1, 0, 3'b111, 64'h0, 64'h0, 64'h0, 1, 5'd20);                    // f3=111 illegal
        txn(1, 0, 3'b011, 64'h18, 64'h0, 64'hA5A5_0000_1234_5678, 3, 5'd21); // LD

        // Reset while a 32-bit load is in ISSUE.
        sel = 1'b0; req_we = 1'b0; req_f3 = 3'b010; req_addr = 64'h100;
        req_rd = 5'd22; req_valid = 1'b1;
        set_idle();
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_ready = 1'b0; exp_mem_req = 1'b1; exp_rv = 1'b0;
        exp_we = 1'b0; exp_addr = 64'h100; exp_strb = 8'h0;
        @(posedge clk); #1;
        #2;
        rst = 1'b1;
        set_idle();
        #1;
        chk("mid-rst mem_req", 64'(o_mem_req), 64'd0);
        chk("mid-rst req_ready", 64'(o_ready), 64'd1);
        chk("mid-rst resp_valid", 64'(o_rv), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        txn(0, 0, 3'b100, 64'h201, 64'h0, 64'h0000_9C00, 2, 5'd23);      // LBU after reset

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
